// File: rtl/y86_pkg.sv
// y86_pkg: shared register IDs and write-back scheduler state encoding.
package y86_pkg;
  localparam logic [3:0] RAX = 4'h0;
  localparam logic [3:0] RCX = 4'h1;
  localparam logic [3:0] RDX = 4'h2;
  localparam logic [3:0] RBX = 4'h3;
  localparam logic [3:0] RSP = 4'h4;
  localparam logic [3:0] RBP = 4'h5;
  localparam logic [3:0] RSI = 4'h6;
  localparam logic [3:0] RDI = 4'h7;
  localparam logic [3:0] R8 = 4'h8;
  localparam logic [3:0] R9 = 4'h9;
  localparam logic [3:0] R10 = 4'hA;
  localparam logic [3:0] R11 = 4'hB;
  localparam logic [3:0] R12 = 4'hC;
  localparam logic [3:0] R13 = 4'hD;
  localparam logic [3:0] R14 = 4'hE;
  localparam logic [3:0] REG_NONE = 4'hF;
  typedef enum logic [1:0] {IDLE, WR_E, WR_M} wb_state_t;
endpackage

// File: rtl/wb_port_sched.sv
// wb_port_sched: serialises the E and M write-backs of one instruction onto a
// single register-file write port, with forwarding from the buffered entry.
module wb_port_sched import y86_pkg::*; #(
  parameter int DATA_W = 64,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_dstE,
  input  logic [3:0]        in_dstM,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [DATA_W-1:0] in_valM,
  output logic              rf_we,
  output logic [3:0]        rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic [3:0]        q_addr,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data,
  output logic              busy
);
  wb_state_t state, state_nx;
  logic [3:0] dst_e, dst_m;
  logic [DATA_W-1:0] val_e, val_m;
  logic accept, m_hit, e_hit;
  // dstE equal to dstM is skipped entirely so the M value wins
  function automatic wb_state_t first_state(input logic [3:0] de, input logic [3:0] dm);
    return (de != REG_NONE && de != dm) ? WR_E : (dm != REG_NONE) ? WR_M : IDLE;
  endfunction
  assign in_ready = state != WR_E || dst_m == REG_NONE;
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = accept ? first_state(in_dstE, in_dstM) : IDLE;
    if (state == WR_E && dst_m != REG_NONE) state_nx = WR_M;
    rf_we = state != IDLE;
    rf_addr = state == WR_E ? dst_e : state == WR_M ? dst_m : REG_NONE;
    rf_data = state == WR_E ? val_e : state == WR_M ? val_m : '0;
  end
  // M is still pending in both WR_E and WR_M; E only in WR_E
  assign m_hit = q_addr != REG_NONE && q_addr == dst_m && state != IDLE;
  assign e_hit = q_addr != REG_NONE && q_addr == dst_e && state == WR_E;
  assign q_hit = m_hit || e_hit;
  assign q_data = m_hit ? val_m : e_hit ? val_e : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dst_e <= REG_NONE;
      dst_m <= REG_NONE;
      val_e <= '0;
      val_m <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        dst_e <= in_dstE;
        dst_m <= in_dstM;
        val_e <= in_valE;
        val_m <= in_valM;
      end
    end
  end
endmodule

// File: doc/wb_port_sched.md
WB_PORT_SCHED -- requirements
Module: wb_port_sched

Interface
REQ-001 Parameter DATA_W, default 64, register/value data width.
REQ-002 Parameter REG_NONE, default 4'hF, register ID meaning "no destination".
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  write-back request from the pipeline.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 in_dstE  input  4  destination for valE; REG_NONE means no write.
REQ-008 in_dstM  input  4  destination for valM; REG_NONE means no write.
REQ-009 in_valE  input  DATA_W  ALU result.
REQ-010 in_valM  input  DATA_W  memory read result.
REQ-011 rf_we  output  1  register-file single write-port enable.
REQ-012 rf_addr  output  4  register-file write address.
REQ-013 rf_data  output  DATA_W  register-file write data.
REQ-014 q_addr  input  4  forwarding lookup register ID.
REQ-015 q_hit  output  1  q_addr matches a buffered, not-yet-written destination.
REQ-016 q_data  output  DATA_W  forwarded value when q_hit; 0 otherwise.
REQ-017 busy  output  1  an entry is buffered (state != IDLE).

Function
REQ-018 Serialise up to two register writes per instruction onto the single write port; one-entry buffer holds dstE, dstM, valE, valM.
REQ-019 FSM states: IDLE, WR_E, WR_M.
REQ-020 Accept = in_valid && in_ready; the entry is latched on that edge; the first write appears the following cycle (latency 1).
REQ-021 in_ready = 1 in IDLE, in WR_M, and in WR_E when buffered dstM == REG_NONE; 0 otherwise.
REQ-022 On accept, next state = WR_E if dstE != REG_NONE and dstE != dstM; else WR_M if dstM != REG_NONE; else IDLE, with no write.
REQ-023 In WR_E: rf_we=1, rf_addr=dstE, rf_data=valE; next = WR_M if dstM != REG_NONE; else the accept rule (REQ-022) if a new entry is accepted; else IDLE.
REQ-024 In WR_M: rf_we=1, rf_addr=dstM, rf_data=valM; next = accept rule if a new entry is accepted, else IDLE.
REQ-025 dstE == dstM != REG_NONE: the E write is skipped and only valM is written (M wins, popq %rsp semantics).
REQ-026 In IDLE: rf_we=0, rf_addr=REG_NONE, rf_data=0.
REQ-027 q_hit=1 if q_addr != REG_NONE and it matches the buffered dstM with the M write still pending; else the buffered dstE with the E write still pending; M has priority and supplies q_data.
REQ-028 A destination written in the current cycle still hits; it no longer hits once the state has advanced past it.
REQ-029 q_hit/q_data are combinational from the buffer and q_addr; the incoming request is never forwarded.
REQ-030 Throughput: one instruction/cycle when each has at most one destination; two cycles per instruction with two distinct destinations.

Reset
REQ-031 Reset asserted: state=IDLE, buffer cleared to dstE=dstM=REG_NONE and values 0, rf_we=0, in_ready=1 once released, q_hit=0, busy=0.
REQ-032 Reset mid-operation discards the buffered entry; the pending write is never issued, including any write in the reset cycle.

Structure
REQ-033 Shared package y86_pkg holds REG_NONE, the register ID constants, and the wb_state_t enum (IDLE, WR_E, WR_M).
REQ-034 No sub-module; FSM plus the buffer register live in wb_port_sched.

Verification
REQ-035 Test: accept dstE=3, valE=0x11, dstM=F -> next cycle rf_we=1, addr=3, data=0x11; in_ready held 1 throughout.
REQ-036 Test: accept dstE=4, valE=0xA0, dstM=2, valM=0xB0 (popq-like) -> cycle+1 writes 4/0xA0, cycle+2 writes 2/0xB0; in_ready=0 during WR_E.
REQ-037 Test: dstE=dstM=4, valE=1, valM=2 -> exactly one write, addr 4 data 2.
REQ-038 Test: dstE=dstM=F (nop) -> no rf_we pulse, busy stays 0; back-to-back irmovq x3 -> three consecutive write cycles.
REQ-039 Test: q_addr=2 during WR_E of REQ-036 -> q_hit=1, q_data=0xB0; q_addr=4 after WR_E completes -> q_hit=0.
REQ-040 Test: reset asserted in WR_E of REQ-036 -> rf_we drops immediately, no WR_M write follows, busy=0.
